// File: rtl/fib_call_stack_ctrl.sv
// Call-stack controller for the fibonacci datapath: frame memory, SP, flags, error FSM.
// Optional high-water-mark tracking is built when FIB_STACK_HWM_EN is defined.
module fib_call_stack_ctrl #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic              tos,
    input  logic [1:0]        c_in,
    input  logic [DATA_W-1:0] d_in,
    output logic [1:0]        c_out,
    output logic [DATA_W-1:0] d_out,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   occupancy,
    output logic              overflow,
    output logic              underflow,
    output logic              cmd_err,
    output logic [ADDR_W:0]   hwm
);

    typedef enum logic {S_READY, S_ERROR} state_t;

    localparam logic [ADDR_W:0] LP_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LP_ONE  = (ADDR_W + 1)'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W:0]     r_sp;
    logic [ADDR_W:0]     w_sp_nxt;
    logic [ADDR_W:0]     w_sp_m1;
    logic [DATA_W+1:0]   r_mem [DEPTH];
    logic [DATA_W+1:0]   w_rd_frame;
    logic [1:0]          r_c_out;
    logic [DATA_W-1:0]   r_d_out;
    logic                r_rd_valid;
    logic                r_ovf;
    logic                r_udf;
    logic                r_cerr;
    logic                w_we;
    logic                w_re;
    logic                w_set_ovf;
    logic                w_set_udf;
    logic                w_set_cerr;
    logic                w_empty;
    logic                w_full;
    logic [1:0]          w_ncmd;

    assign w_empty    = (r_sp == '0);
    assign w_full     = (r_sp == LP_FULL);
    assign w_sp_m1    = r_sp - LP_ONE;
    assign w_ncmd     = {1'b0, push} + {1'b0, pop} + {1'b0, tos};
    assign w_rd_frame = r_mem[w_sp_m1[ADDR_W-1:0]];

    always_comb begin
        w_state_nxt = r_state;
        w_sp_nxt    = r_sp;
        w_we        = 1'b0;
        w_re        = 1'b0;
        w_set_ovf   = 1'b0;
        w_set_udf   = 1'b0;
        w_set_cerr  = 1'b0;
        if (r_state == S_READY) begin
            if (w_ncmd > 2'd1) begin
                w_set_cerr  = 1'b1;
                w_state_nxt = S_ERROR;
            end else if (push) begin
                if (w_full) begin
                    w_set_ovf   = 1'b1;
                    w_state_nxt = S_ERROR;
                end else begin
                    w_we     = 1'b1;
                    w_sp_nxt = r_sp + LP_ONE;
                end
            end else if (pop || tos) begin
                if (w_empty) begin
                    w_set_udf   = 1'b1;
                    w_state_nxt = S_ERROR;
                end else begin
                    w_re = 1'b1;
                    if (pop) w_sp_nxt = w_sp_m1;
                end
            end
        end
        // clear overrides whatever command arrived in the same cycle
        if (clear) begin
            w_state_nxt = S_READY;
            w_sp_nxt    = '0;
            w_we        = 1'b0;
            w_re        = 1'b0;
            w_set_ovf   = 1'b0;
            w_set_udf   = 1'b0;
            w_set_cerr  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_READY;
            r_sp       <= '0;
            r_rd_valid <= 1'b0;
            r_c_out    <= '0;
            r_d_out    <= '0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
            r_cerr     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sp       <= w_sp_nxt;
            r_rd_valid <= w_re;
            if (w_re) begin
                r_c_out <= w_rd_frame[DATA_W+1:DATA_W];
                r_d_out <= w_rd_frame[DATA_W-1:0];
            end
            if (clear) begin
                r_ovf  <= 1'b0;
                r_udf  <= 1'b0;
                r_cerr <= 1'b0;
            end else begin
                r_ovf  <= r_ovf  | w_set_ovf;
                r_udf  <= r_udf  | w_set_udf;
                r_cerr <= r_cerr | w_set_cerr;
            end
        end
    end

    // Frame storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_sp[ADDR_W-1:0]] <= {c_in, d_in};
    end

`ifdef FIB_STACK_HWM_EN
    logic [ADDR_W:0] r_hwm;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   r_hwm <= '0;
        else if (clear)             r_hwm <= '0;
        else if (w_sp_nxt > r_hwm)  r_hwm <= w_sp_nxt;
    end
    assign hwm = r_hwm;
`else
    assign hwm = '0;
`endif

    assign c_out     = r_c_out;
    assign d_out     = r_d_out;
    assign rd_valid  = r_rd_valid;
    assign empty     = w_empty;
    assign full      = w_full;
    assign occupancy = r_sp;
    assign overflow  = r_ovf;
    assign underflow = r_udf;
    assign cmd_err   = r_cerr;

endmodule

// File: tb/tb_fib_call_stack_ctrl.sv
// Bench for fib_call_stack_ctrl: directed plan steps plus random traffic vs. a queue-based model.
module tb_fib_call_stack_ctrl;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              clear = 1'b0, push = 1'b0, pop = 1'b0, tos = 1'b0;
    logic [1:0]        c_in = '0;
    logic [DATA_W-1:0] d_in = '0;
    logic [1:0]        c_out;
    logic [DATA_W-1:0] d_out;
    logic              rd_valid, empty, full, overflow, underflow, cmd_err;
    logic [ADDR_W:0]   occupancy, hwm;

    fib_call_stack_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .clear(clear), .push(push), .pop(pop), .tos(tos),
        .c_in(c_in), .d_in(d_in), .c_out(c_out), .d_out(d_out), .rd_valid(rd_valid),
        .empty(empty), .full(full), .occupancy(occupancy), .overflow(overflow),
        .underflow(underflow), .cmd_err(cmd_err), .hwm(hwm)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the stack is a queue of {code, arg} frames
    logic [DATA_W+1:0] m_q[$];
    logic [DATA_W+1:0] m_last;
    logic m_rdv, m_ovf, m_udf, m_cerr, m_err;
    int   m_hwm;

    function automatic void model_reset();
        m_q.delete();
        m_last = '0;
        m_rdv = 0; m_ovf = 0; m_udf = 0; m_cerr = 0; m_err = 0; m_hwm = 0;
    endfunction

    function automatic void model_step(logic p, logic o, logic t, logic clr,
                                       logic [1:0] c, logic [DATA_W-1:0] d);
        m_rdv = 0;
        if (clr) begin
            m_q.delete();
            m_ovf = 0; m_udf = 0; m_cerr = 0; m_err = 0; m_hwm = 0;
        end else if (!m_err) begin
            if (int'(p) + int'(o) + int'(t) > 1) begin
                m_cerr = 1; m_err = 1;
            end else if (p) begin
                if (m_q.size() == DEPTH) begin m_ovf = 1; m_err = 1; end
                else m_q.push_back({c, d});
            end else if (o || t) begin
                if (m_q.size() == 0) begin m_udf = 1; m_err = 1; end
                else begin
                    m_last = m_q[$];
                    if (o) void'(m_q.pop_back());
                    m_rdv = 1;
                end
            end
        end
`ifdef FIB_STACK_HWM_EN
        if (m_q.size() > m_hwm) m_hwm = m_q.size();
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ":occupancy"}, 32'(occupancy), m_q.size());
        chk({ctx, ":empty"},     32'(empty),     32'(m_q.size() == 0));
        chk({ctx, ":full"},      32'(full),      32'(m_q.size() == DEPTH));
        chk({ctx, ":rd_valid"},  32'(rd_valid),  32'(m_rdv));
        chk({ctx, ":c_out"},     32'(c_out),     32'(m_last[DATA_W+1:DATA_W]));
        chk({ctx, ":d_out"},     32'(d_out),     32'(m_last[DATA_W-1:0]));
        chk({ctx, ":overflow"},  32'(overflow),  32'(m_ovf));
        chk({ctx, ":underflow"}, 32'(underflow), 32'(m_udf));
        chk({ctx, ":cmd_err"},   32'(cmd_err),   32'(m_cerr));
        chk({ctx, ":hwm"},       32'(hwm),       m_hwm);
    endtask

    task automatic cyc(input string ctx, input logic p, input logic o, input logic t,
                       input logic clr, input logic [1:0] c, input logic [DATA_W-1:0] d);
        @(negedge clk);
        push = p; pop = o; tos = t; clear = clr; c_in = c; d_in = d;
        @(posedge clk);
        model_step(p, o, t, clr, c, d);
        #1;
        check_all(ctx);
    endtask

    task automatic idle(input string ctx);
        cyc(ctx, 0, 0, 0, 0, 2'd0, '0);
    endtask

    initial begin
        model_reset();
        @(posedge clk); #1;
        check_all("reset");
        @(negedge clk); rst = 1'b1;

        // LIFO order
        cyc("push1", 1, 0, 0, 0, 2'd1, 8'd5);
        cyc("push2", 1, 0, 0, 0, 2'd2, 8'd4);
        cyc("push3", 1, 0, 0, 0, 2'd0, 8'd3);
        cyc("pop1",  0, 1, 0, 0, 2'd0, '0);
        cyc("pop2",  0, 1, 0, 0, 2'd0, '0);
        cyc("pop3",  0, 1, 0, 0, 2'd0, '0);
        idle("after_pops");

        // tos leaves SP alone
        cyc("push_t", 1, 0, 0, 0, 2'd1, 8'd9);
        cyc("tos1",   0, 0, 1, 0, 2'd0, '0);
        cyc("tos2",   0, 0, 1, 0, 2'd0, '0);
        cyc("pop_t",  0, 1, 0, 0, 2'd0, '0);
        idle("after_tos");

        // Fill, overflow, ignored pop, clear, recovery
        for (int i = 0; i < DEPTH; i++) cyc("fill", 1, 0, 0, 0, 2'(i), 8'(i));
        cyc("ovf_push",  1, 0, 0, 0, 2'd3, 8'hAA);
        cyc("err_pop",   0, 1, 0, 0, 2'd0, '0);
        idle("err_idle");
        cyc("clr_ovf",   0, 0, 0, 1, 2'd0, '0);
        cyc("push_rec",  1, 0, 0, 0, 2'd2, 8'h77);
        cyc("tos_rec",   0, 0, 1, 0, 2'd0, '0);
        cyc("clr_rec",   0, 0, 0, 1, 2'd0, '0);

        // Underflow on empty, tos ignored until clear
        cyc("udf_pop",   0, 1, 0, 0, 2'd0, '0);
        cyc("udf_tos",   0, 0, 1, 0, 2'd0, '0);
        cyc("udf_push",  1, 0, 0, 0, 2'd1, 8'h11);
        cyc("clr_udf",   0, 0, 0, 1, 2'd0, '0);

        // Command conflict and clear priority
        cyc("pre_conf",  1, 0, 0, 0, 2'd3, 8'h21);
        cyc("conflict",  1, 1, 0, 0, 2'd1, 8'h22);
        cyc("clr_conf",  0, 0, 0, 1, 2'd0, '0);
        cyc("clr_push",  1, 0, 0, 1, 2'd2, 8'h33);
        cyc("tos_empty", 0, 0, 1, 0, 2'd0, '0);
        cyc("clr_tos",   0, 0, 0, 1, 2'd0, '0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if      (r < 40) cyc("rnd", 1, 0, 0, 0, 2'($urandom), 8'($urandom));
            else if (r < 62) cyc("rnd", 0, 1, 0, 0, 2'($urandom), 8'($urandom));
            else if (r < 76) cyc("rnd", 0, 0, 1, 0, 2'($urandom), 8'($urandom));
            else if (r < 79) cyc("rnd", 1, 0, 1, 0, 2'($urandom), 8'($urandom));
            else if (r < 85) cyc("rnd", $urandom_range(0, 1) == 1, 0, 0, 1, 2'($urandom), 8'($urandom));
            else             cyc("rnd", 0, 0, 0, 0, 2'($urandom), 8'($urandom));
        end

        // Reset during a pop
        cyc("clr_pre_rst", 0, 0, 0, 1, 2'd0, '0);
        for (int i = 0; i < 5; i++) cyc("rst_fill", 1, 0, 0, 0, 2'(i), 8'(i + 40));
        cyc("rst_pop1", 0, 1, 0, 0, 2'd0, '0);
        cyc("rst_pop2", 0, 1, 0, 0, 2'd0, '0);
        @(negedge clk);
        push = 0; pop = 1; tos = 0; clear = 0;
        #2 rst = 1'b0;
        model_reset();
        #1 check_all("in_reset");
        @(posedge clk); #1;
        check_all("reset_edge");
        @(negedge clk); pop = 0; rst = 1'b1;
        idle("post_rst");
        cyc("pop_after_rst", 0, 1, 0, 0, 2'd0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
